spi_ram_ctrl: RTL and testbench
===============================

// Module: spi_ram_ctrl
// PURPOSE
//  Command decoder plus single-port RAM, directly downstream of the SPI slave.
//  Consumes the slave's rx_valid/rx_data frames: write address, write data, read address, read data.
//  Returns read bytes to the slave on tx_valid/tx_data, which the slave then shifts out on miso.
//  One clock domain, shared with the SPI slave.
// PARAMETERS
//  ADDR_width  8    address and data byte width; rx_data is ADDR_width+2 bits wide
//  MEM_DEPTH   256  number of words; legal range 2 .. 2**ADDR_width
// PORTS
//  clk       in   1             system clock, shared with the SPI slave
//  rst       in   1             asynchronous, active-high reset
//  rx_valid  in   1             one-cycle strobe: rx_data holds a complete frame
//  rx_data   in   ADDR_width+2  [ADDR_width+1:ADDR_width] = cmd, [ADDR_width-1:0] = payload
//  tx_valid  out  1             one-cycle strobe: tx_data holds the read byte
//  tx_data   out  ADDR_width    read data; holds its value between reads
//  cmd_err   out  1             one-cycle strobe: protocol or range error
// BEHAVIOUR
//  Reset values: tx_valid=0, tx_data=0, cmd_err=0, wr_addr=0, rd_addr=0, FSM=IDLE.
//  RAM contents are not reset.
//  Frames are decoded only on cycles where rx_valid=1.
//  Back-to-back strobes are all processed; there is no backpressure.
//  CMD_WR_ADDR (2'b00): wr_addr <= payload.
//  CMD_WR_DATA (2'b01): mem[wr_addr] <= payload, written at this edge.
//  CMD_RD_ADDR (2'b10): rd_addr <= payload; FSM -> RD_READY.
//  CMD_RD_DATA (2'b11), FSM in RD_READY:
//    - tx_data <= mem[rd_addr].
//    - tx_valid=1 exactly one cycle after the rx_valid cycle.
//    - FSM stays in RD_READY, so repeated reads are allowed.
//  CMD_RD_DATA (2'b11), FSM in IDLE:
//    - tx_valid stays 0; tx_data is unchanged.
//    - cmd_err=1 for one cycle, the cycle after rx_valid.
//  FSM states:
//    - IDLE     -> RD_READY on CMD_RD_ADDR.
//    - RD_READY -> RD_READY on any command.
//    - Only rst returns the FSM to IDLE.
//  Out-of-range address (addr >= MEM_DEPTH):
//    - WR_DATA: write is dropped, cmd_err pulses.
//    - RD_DATA: tx_data=0, tx_valid pulses, cmd_err pulses in the same cycle.
//  Write then read of the same address on consecutive strobes: the read returns the new data.
//  rx_valid is always 0 in the cycle after a strobe, so write and read never coincide.
//  Reset mid-operation:
//    - A pending tx_valid/cmd_err is cancelled.
//    - Pointers clear to 0; FSM returns to IDLE.
//    - RAM keeps its old contents.
//  tx_valid and cmd_err are registered outputs.
//  Neither strobe stays high for two consecutive cycles unless two read strobes arrive back-to-back.
// CONFIGURATION
//  SPI_RAM_AUTOINC_EN defined:
//    - After each accepted WR_DATA, wr_addr <= wr_addr+1.
//    - After each RD_DATA issued in RD_READY, rd_addr <= rd_addr+1.
//    - Both wrap from MEM_DEPTH-1 to 0; out-of-range pointers also wrap to 0.
//  SPI_RAM_AUTOINC_EN undefined: pointers change only on WR_ADDR/RD_ADDR.
// STRUCTURE
//  Package spi_pkg:
//    - typedef enum logic[1:0] cmd_e {CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA}
//    - typedef enum logic rd_state_e {IDLE, RD_READY}
//    - localparam CMD_W = 2
//  Sub-module spi_ram_mem: storage array with synchronous write and registered synchronous read.
//  spi_ram_ctrl holds the decode, pointers, FSM, range check and the tx/err strobes.
// TESTING
//  1. Reset, then RD_DATA 0x3FF with no RD_ADDR -> cmd_err=1 one cycle later; tx_valid=0; tx_data=0.
//  2. WR_ADDR 0x012, WR_DATA 0x1A5, RD_ADDR 0x212, RD_DATA 0x300 -> tx_valid one cycle after the last strobe, tx_data=0xA5.
//  3. Back-to-back strobes on consecutive-ish cycles: WR_ADDR 0x0FF, WR_DATA 0x13C, RD_ADDR 0x2FF, RD_DATA
//     -> tx_data=0x3C; no cmd_err.
//  4. MEM_DEPTH=128, WR_ADDR 0x090, WR_DATA 0x155 -> cmd_err pulse, RAM unchanged.
//     Then RD_ADDR 0x290, RD_DATA -> tx_data=0x00 with tx_valid and cmd_err together.
//  5. AUTOINC_EN: WR_ADDR 0x0FF, WR_DATA 0x111, WR_DATA 0x122 -> mem[0xFF]=0x11, mem[0x00]=0x22 (wrap).
//     Reading from RD_ADDR 0x2FF twice -> 0x11 then 0x22.
//  6. rst asserted the cycle after RD_DATA -> tx_valid stays 0; FSM=IDLE.
//     A following RD_DATA -> cmd_err; RAM data is retained.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared command and read-state encodings for the SPI RAM controller.
package spi_pkg;

  localparam int CMD_W = 2;

  typedef enum logic [CMD_W-1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic {
    IDLE     = 1'b0,
    RD_READY = 1'b1
  } rd_state_e;

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port storage array: synchronous write, registered synchronous read.
// The read register is reset and can be forced to zero for out-of-range reads.
module spi_ram_mem #(
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int IDX_W     = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic              rzero_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Array contents are deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= rzero_i ? '0 : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder, pointers, read FSM and error strobes in front of spi_ram_mem.
// Optional macro SPI_RAM_AUTOINC_EN: post-increment (with wrap) of both pointers.
module spi_ram_ctrl
  import spi_pkg::*;
#(
  parameter int ADDR_width = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        rx_valid_i,
  input  logic [ADDR_width+CMD_W-1:0] rx_data_i,
  output logic                        tx_valid_o,
  output logic [ADDR_width-1:0]       tx_data_o,
  output logic                        cmd_err_o
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_width:0] DEPTH_W = (ADDR_width+1)'(MEM_DEPTH);

`ifdef SPI_RAM_AUTOINC_EN
  localparam logic [ADDR_width-1:0] LAST_ADDR = ADDR_width'(MEM_DEPTH - 1);

  // Pointers already past the end also fall back to zero.
  function automatic logic [ADDR_width-1:0] next_ptr(input logic [ADDR_width-1:0] p);
    return (p >= LAST_ADDR) ? '0 : p + ADDR_width'(1);
  endfunction
`endif

  rd_state_e state_q, state_d;
  logic [ADDR_width-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_width-1:0] rd_addr_q, rd_addr_d;
  logic tx_valid_q, tx_valid_d;
  logic cmd_err_q, cmd_err_d;

  cmd_e cmd;
  logic [ADDR_width-1:0] payload;
  logic wr_in_range, rd_in_range;
  logic mem_we, mem_re, mem_rzero;

  assign cmd         = cmd_e'(rx_data_i[ADDR_width+CMD_W-1 -: CMD_W]);
  assign payload     = rx_data_i[ADDR_width-1:0];
  assign wr_in_range = ({1'b0, wr_addr_q} < DEPTH_W);
  assign rd_in_range = ({1'b0, rd_addr_q} < DEPTH_W);

  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    tx_valid_d = 1'b0;
    cmd_err_d  = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_rzero  = 1'b0;
    if (rx_valid_i) begin
      unique case (cmd)
        CMD_WR_ADDR: wr_addr_d = payload;
        CMD_WR_DATA: begin
          mem_we    = wr_in_range;
          cmd_err_d = !wr_in_range;
`ifdef SPI_RAM_AUTOINC_EN
          wr_addr_d = next_ptr(wr_addr_q);
`endif
        end
        CMD_RD_ADDR: begin
          rd_addr_d = payload;
          state_d   = RD_READY;
        end
        CMD_RD_DATA: begin
          // A read before any RD_ADDR is a protocol error and leaves tx_data alone.
          if (state_q == RD_READY) begin
            mem_re     = 1'b1;
            mem_rzero  = !rd_in_range;
            tx_valid_d = 1'b1;
            cmd_err_d  = !rd_in_range;
`ifdef SPI_RAM_AUTOINC_EN
            rd_addr_d  = next_ptr(rd_addr_q);
`endif
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      tx_valid_q <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      tx_valid_q <= tx_valid_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  spi_ram_mem #(
    .DATA_W   (ADDR_width),
    .MEM_DEPTH(MEM_DEPTH),
    .IDX_W    (IDX_W)
  ) u_mem (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_i   (mem_we),
    .waddr_i(wr_addr_q[IDX_W-1:0]),
    .wdata_i(payload),
    .re_i   (mem_re),
    .rzero_i(mem_rzero),
    .raddr_i(rd_addr_q[IDX_W-1:0]),
    .rdata_o(tx_data_o)
  );

  assign tx_valid_o = tx_valid_q;
  assign cmd_err_o  = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl: a 256-word instance and a 128-word instance.
module tb_spi_ram_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxValid = 1'b0, rxValid128 = 1'b0;
  logic [9:0] rxData = '0, rxData128 = '0;
  logic txValid, txValid128, cmdErr, cmdErr128;
  logic [7:0] txData, txData128;
  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  spi_ram_ctrl #(.ADDR_width(8), .MEM_DEPTH(256)) dut (
    .clk_i(clk), .rst_i(rst), .rx_valid_i(rxValid), .rx_data_i(rxData),
    .tx_valid_o(txValid), .tx_data_o(txData), .cmd_err_o(cmdErr)
  );

  spi_ram_ctrl #(.ADDR_width(8), .MEM_DEPTH(128)) dut128 (
    .clk_i(clk), .rst_i(rst), .rx_valid_i(rxValid128), .rx_data_i(rxData128),
    .tx_valid_o(txValid128), .tx_data_o(txData128), .cmd_err_o(cmdErr128)
  );

  // One-cycle strobe; returns on the following falling edge so results are visible.
  task automatic applyStimulus(input bit sel128, input logic [9:0] frame);
    @(negedge clk);
    if (sel128) begin rxValid128 = 1'b1; rxData128 = frame; end
    else begin rxValid = 1'b1; rxData = frame; end
    @(negedge clk);
    rxValid = 1'b0;
    rxValid128 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    testsRun++; if (txValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_tx_valid: got %b expected 0", txValid); end
    testsRun++; if (txData !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_tx_data: got %h expected 00", txData); end
    testsRun++; if (cmdErr !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_cmd_err: got %b expected 0", cmdErr); end
    testsRun++; if (cmdErr128 !== 1'b0 || txValid128 !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_dut128: got err=%b valid=%b expected 0 0", cmdErr128, txValid128); end
    rst = 1'b0;
  endtask

  task automatic test_read_idle();
    applyStimulus(1'b0, 10'h3FF);
    testsRun++; if (cmdErr !== 1'b1) begin testsFailed++; $display("[TB] FAIL idle_rd_err: got %b expected 1", cmdErr); end
    testsRun++; if (txValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL idle_rd_valid: got %b expected 0", txValid); end
    testsRun++; if (txData !== 8'h00) begin testsFailed++; $display("[TB] FAIL idle_rd_data: got %h expected 00", txData); end
    @(negedge clk);
    testsRun++; if (cmdErr !== 1'b0) begin testsFailed++; $display("[TB] FAIL idle_rd_err_pulse: got %b expected 0", cmdErr); end
  endtask

  task automatic test_write_read();
    applyStimulus(1'b0, 10'h012);
    applyStimulus(1'b0, 10'h1A5);
    applyStimulus(1'b0, 10'h212);
    applyStimulus(1'b0, 10'h300);
    testsRun++; if (txValid !== 1'b1) begin testsFailed++; $display("[TB] FAIL wr_rd_valid: got %b expected 1", txValid); end
    testsRun++; if (txData !== 8'hA5) begin testsFailed++; $display("[TB] FAIL wr_rd_data: got %h expected a5", txData); end
    testsRun++; if (cmdErr !== 1'b0) begin testsFailed++; $display("[TB] FAIL wr_rd_err: got %b expected 0", cmdErr); end
    @(negedge clk);
    testsRun++; if (txValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL wr_rd_valid_pulse: got %b expected 0", txValid); end
    testsRun++; if (txData !== 8'hA5) begin testsFailed++; $display("[TB] FAIL wr_rd_data_hold: got %h expected a5", txData); end
  endtask

  task automatic test_back_to_back();
    applyStimulus(1'b0, 10'h0FF);
    applyStimulus(1'b0, 10'h13C);
    applyStimulus(1'b0, 10'h2FF);
    applyStimulus(1'b0, 10'h300);
    testsRun++; if (txValid !== 1'b1 || txData !== 8'h3C) begin testsFailed++; $display("[TB] FAIL b2b_read: got valid=%b data=%h expected 1 3c", txValid, txData); end
    testsRun++; if (cmdErr !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_err: got %b expected 0", cmdErr); end
  endtask

  task automatic test_out_of_range();
    applyStimulus(1'b1, 10'h010);
    applyStimulus(1'b1, 10'h177);
    applyStimulus(1'b1, 10'h090);
    applyStimulus(1'b1, 10'h155);
    testsRun++; if (cmdErr128 !== 1'b1) begin testsFailed++; $display("[TB] FAIL oor_wr_err: got %b expected 1", cmdErr128); end
    applyStimulus(1'b1, 10'h210);
    applyStimulus(1'b1, 10'h300);
    testsRun++; if (txData128 !== 8'h77 || cmdErr128 !== 1'b0) begin testsFailed++; $display("[TB] FAIL oor_ram_kept: got data=%h err=%b expected 77 0", txData128, cmdErr128); end
    applyStimulus(1'b1, 10'h290);
    applyStimulus(1'b1, 10'h300);
    testsRun++; if (txValid128 !== 1'b1 || cmdErr128 !== 1'b1) begin testsFailed++; $display("[TB] FAIL oor_rd_strobes: got valid=%b err=%b expected 1 1", txValid128, cmdErr128); end
    testsRun++; if (txData128 !== 8'h00) begin testsFailed++; $display("[TB] FAIL oor_rd_data: got %h expected 00", txData128); end
    applyStimulus(1'b1, 10'h07F);
    applyStimulus(1'b1, 10'h15A);
    testsRun++; if (cmdErr128 !== 1'b0) begin testsFailed++; $display("[TB] FAIL last_addr_wr_err: got %b expected 0", cmdErr128); end
    applyStimulus(1'b1, 10'h27F);
    applyStimulus(1'b1, 10'h300);
    testsRun++; if (txData128 !== 8'h5A || cmdErr128 !== 1'b0) begin testsFailed++; $display("[TB] FAIL last_addr_rd: got data=%h err=%b expected 5a 0", txData128, cmdErr128); end
  endtask

`ifdef SPI_RAM_AUTOINC_EN
  task automatic test_autoinc();
    applyStimulus(1'b0, 10'h0FF);
    applyStimulus(1'b0, 10'h111);
    applyStimulus(1'b0, 10'h122);
    applyStimulus(1'b0, 10'h2FF);
    applyStimulus(1'b0, 10'h300);
    testsRun++; if (txData !== 8'h11) begin testsFailed++; $display("[TB] FAIL autoinc_rd0: got %h expected 11", txData); end
    applyStimulus(1'b0, 10'h300);
    testsRun++; if (txData !== 8'h22 || txValid !== 1'b1) begin testsFailed++; $display("[TB] FAIL autoinc_rd1_wrap: got data=%h valid=%b expected 22 1", txData, txValid); end
  endtask
`else
  task automatic test_pointer_hold();
    applyStimulus(1'b0, 10'h040);
    applyStimulus(1'b0, 10'h1AA);
    applyStimulus(1'b0, 10'h1BB);
    applyStimulus(1'b0, 10'h041);
    applyStimulus(1'b0, 10'h1CC);
    applyStimulus(1'b0, 10'h240);
    applyStimulus(1'b0, 10'h300);
    testsRun++; if (txData !== 8'hBB) begin testsFailed++; $display("[TB] FAIL hold_rd0: got %h expected bb", txData); end
    applyStimulus(1'b0, 10'h300);
    testsRun++; if (txData !== 8'hBB || txValid !== 1'b1) begin testsFailed++; $display("[TB] FAIL hold_rd1: got data=%h valid=%b expected bb 1", txData, txValid); end
  endtask
`endif

  task automatic test_reset_mid();
    applyStimulus(1'b0, 10'h020);
    applyStimulus(1'b0, 10'h1E7);
    applyStimulus(1'b0, 10'h220);
    @(negedge clk);
    rxValid = 1'b1;
    rxData = 10'h300;
    @(negedge clk);
    rxValid = 1'b0;
    rst = 1'b1;
    #1;
    testsRun++; if (txValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_valid: got %b expected 0", txValid); end
    testsRun++; if (txData !== 8'h00) begin testsFailed++; $display("[TB] FAIL midrst_data: got %h expected 00", txData); end
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 10'h300);
    testsRun++; if (cmdErr !== 1'b1 || txValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_idle: got err=%b valid=%b expected 1 0", cmdErr, txValid); end
    applyStimulus(1'b0, 10'h1D4);
    applyStimulus(1'b0, 10'h220);
    applyStimulus(1'b0, 10'h300);
    testsRun++; if (txData !== 8'hE7) begin testsFailed++; $display("[TB] FAIL midrst_ram_kept: got %h expected e7", txData); end
    applyStimulus(1'b0, 10'h200);
    applyStimulus(1'b0, 10'h300);
    testsRun++; if (txData !== 8'hD4) begin testsFailed++; $display("[TB] FAIL midrst_wr_ptr_zero: got %h expected d4", txData); end
  endtask

  initial begin
    test_reset();
    test_read_idle();
    test_write_read();
    test_back_to_back();
    test_out_of_range();
`ifdef SPI_RAM_AUTOINC_EN
    test_autoinc();
`else
    test_pointer_hold();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
